// File: rtl/memory_data_latch_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_data_latch_if
//  Description : Bundles the request, memory and consumer bus signals of the
//                memory data latch.
//                slave  - the latch itself
//                         (drives memAddress, memReadReq, busOutputs,
//                          dataValid, busy and timeoutError)
//                master - the surrounding logic, i.e. the requester, the
//                         memory and the consuming registers
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_data_latch_if #(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int OUTPUT_COUNT = 1
);
    logic                          startRead;
    logic [ADDR_WIDTH-1:0]         address;
    logic [ADDR_WIDTH-1:0]         memAddress;
    logic                          memReadReq;
    logic                          memReady;
    logic [WIDTH-1:0]              memData;
    logic                          consume;
    logic [WIDTH*OUTPUT_COUNT-1:0] busOutputs;
    logic                          dataValid;
    logic                          busy;
    logic                          timeoutError;

    modport slave (
        input  startRead, address, memReady, memData, consume,
        output memAddress, memReadReq, busOutputs, dataValid, busy, timeoutError
    );

    modport master (
        output startRead, address, memReady, memData, consume,
        input  memAddress, memReadReq, busOutputs, dataValid, busy, timeoutError
    );
endinterface
`default_nettype wire

// File: rtl/memory_data_latch.sv
`default_nettype none
// ============================================================================
//  Module      : memory_data_latch
//  Description : Input data latch between external memory and the internal
//                dataflow registers. Issues one read per request, waits for
//                memReady (with an optional timeout), captures the byte and
//                presents it replicated on busOutputs until it is consumed.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - memory_data_latch_if.slave
//                       (request, memory and consumer signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_data_latch #(
    parameter int               WIDTH         = 8,
    parameter int               ADDR_WIDTH    = 16,
    parameter int               OUTPUT_COUNT  = 1,
    parameter int               TIMEOUT       = 15,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    memory_data_latch_if.slave  bus
);

    // A TIMEOUT of 0 still needs a 1-bit counter so that the logic elaborates.
    localparam int              CNT_W      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_latch;
    logic [WIDTH-1:0]       w_latch_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  w_addr_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_timeout_nxt;
    logic                   r_req;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_timeout;

    // Next-state and next-data logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_latch_nxt   = r_latch;
        w_addr_nxt    = r_addr;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.startRead) begin
                    w_state_nxt = S_REQ;
                    w_addr_nxt  = bus.address;
                    w_cnt_nxt   = '0;
                end
            end
            S_REQ: begin
                // memReady is checked first so that it wins over a timeout
                // on the same edge.
                if (bus.memReady) begin
                    w_state_nxt = S_FULL;
                    w_latch_nxt = bus.memData;
                end else if ((TIMEOUT != 0) && (r_cnt == C_TIMEOUT)) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_FULL: begin
                // startRead without consume is dropped, not queued.
                if (bus.consume) begin
                    if (bus.startRead) begin
                        w_state_nxt = S_REQ;
                        w_addr_nxt  = bus.address;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; status outputs are registered from the
    // next state so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_latch   <= DEFAULT_VALUE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_latch   <= w_latch_nxt;
            r_addr    <= w_addr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_req     <= (w_state_nxt == S_REQ);
            r_valid   <= (w_state_nxt == S_FULL);
            r_busy    <= (w_state_nxt == S_REQ);
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.memAddress   = r_addr;
    assign bus.memReadReq   = r_req;
    assign bus.busOutputs   = {OUTPUT_COUNT{r_latch}};
    assign bus.dataValid    = r_valid;
    assign bus.busy         = r_busy;
    assign bus.timeoutError = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_memory_data_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_data_latch
//  Description : Self-checking bench for memory_data_latch
//                (WIDTH=8, OUTPUT_COUNT=2, TIMEOUT=3). Expected read
//                outcomes are queued when a read is issued and compared when
//                the latch presents data or reports a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_data_latch;

    localparam int WIDTH        = 8;
    localparam int ADDR_WIDTH   = 16;
    localparam int OUTPUT_COUNT = 2;
    localparam int TIMEOUT      = 3;

    typedef struct packed {
        logic             is_timeout;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb_q[$];

    memory_data_latch_if #(
        .WIDTH       (WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .OUTPUT_COUNT(OUTPUT_COUNT)
    ) bus ();

    memory_data_latch #(
        .WIDTH        (WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .OUTPUT_COUNT (OUTPUT_COUNT),
        .TIMEOUT      (TIMEOUT),
        .DEFAULT_VALUE(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then stable and inputs may be changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.startRead = 1'b0;
        bus.address   = '0;
        bus.memReady  = 1'b0;
        bus.memData   = '0;
        bus.consume   = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.startRead = 1'b1;
        bus.address   = 16'hBEEF;
        bus.memReady  = 1'b1;
        bus.memData   = 8'hFF;
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if (bus.busOutputs !== 16'h0000) begin
            errors++; $display("FAIL reset_bus: got %h want 0000", bus.busOutputs);
        end
        checks++;
        if ({bus.dataValid, bus.memReadReq, bus.busy, bus.timeoutError} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000",
                {bus.dataValid, bus.memReadReq, bus.busy, bus.timeoutError});
        end
        checks++;
        if (bus.memAddress !== 16'h0000) begin
            errors++; $display("FAIL reset_addr: got %h want 0000", bus.memAddress);
        end
        tick();
        checks++;
        if ({bus.memReadReq, bus.dataValid} !== 2'b00) begin
            errors++; $display("FAIL reset_idle: got %b want 00", {bus.memReadReq, bus.dataValid});
        end
    endtask

    task automatic test_zero_wait();
        exp_t e;
        bus.address   = 16'h1234;
        bus.startRead = 1'b1;
        tick();
        bus.startRead = 1'b0;
        bus.memReady  = 1'b1;
        bus.memData   = 8'hA5;
        sb_q.push_back('{is_timeout: 1'b0, data: 8'hA5});
        checks++;
        if ({bus.memReadReq, bus.busy, bus.dataValid} !== 3'b110 || bus.memAddress !== 16'h1234) begin
            errors++; $display("FAIL zw_req: got req/busy/valid=%b addr=%h want 110 1234",
                {bus.memReadReq, bus.busy, bus.dataValid}, bus.memAddress);
        end
        tick();
        bus.memReady = 1'b0;
        checks++;
        if ({bus.memReadReq, bus.dataValid} !== 2'b01) begin
            errors++; $display("FAIL zw_valid: got req/valid=%b want 01", {bus.memReadReq, bus.dataValid});
        end
        e = sb_q.pop_front();
        checks++;
        if (bus.busOutputs !== {OUTPUT_COUNT{e.data}}) begin
            errors++; $display("FAIL zw_data: got %h want %h", bus.busOutputs, {OUTPUT_COUNT{e.data}});
        end
        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
        checks++;
        if (bus.dataValid !== 1'b0 || bus.busOutputs !== 16'hA5A5) begin
            errors++; $display("FAIL zw_consume: got valid=%b bus=%h want 0 a5a5",
                bus.dataValid, bus.busOutputs);
        end
    endtask

    // Issues a read and holds memReady low for `waits` REQ cycles, then
    // asserts it (if ready_last) in the following cycle.
    task automatic test_wait_states(input int waits, input logic ready_last,
                                    input logic [WIDTH-1:0] data);
        exp_t e;
        bus.address   = 16'h0300;
        bus.startRead = 1'b1;
        tick();
        bus.startRead = 1'b0;
        sb_q.push_back('{is_timeout: !ready_last, data: ready_last ? data : bus.busOutputs[WIDTH-1:0]});
        for (int i = 0; i < waits; i++) begin
            checks++;
            if (bus.memReadReq !== 1'b1 || bus.timeoutError !== 1'b0) begin
                errors++; $display("FAIL ws_wait%0d: got req=%b err=%b want 1 0",
                    i, bus.memReadReq, bus.timeoutError);
            end
            tick();
        end
        bus.memReady = ready_last;
        bus.memData  = data;
        tick();
        bus.memReady = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (bus.timeoutError !== e.is_timeout || bus.dataValid !== !e.is_timeout
            || bus.memReadReq !== 1'b0) begin
            errors++; $display("FAIL ws_outcome: got err=%b valid=%b req=%b want err=%b valid=%b req=0",
                bus.timeoutError, bus.dataValid, bus.memReadReq, e.is_timeout, !e.is_timeout);
        end
        checks++;
        if (bus.busOutputs !== {OUTPUT_COUNT{e.data}}) begin
            errors++; $display("FAIL ws_data: got %h want %h", bus.busOutputs, {OUTPUT_COUNT{e.data}});
        end
        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
        checks++;
        if (bus.timeoutError !== 1'b0 || bus.dataValid !== 1'b0) begin
            errors++; $display("FAIL ws_after: got err=%b valid=%b want 0 0",
                bus.timeoutError, bus.dataValid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        bus.address   = 16'h1000;
        bus.startRead = 1'b1;
        tick();
        bus.startRead = 1'b0;
        bus.memReady  = 1'b1;
        bus.memData   = 8'h11;
        tick();
        bus.memReady  = 1'b0;
        bus.address   = 16'h3000;
        bus.startRead = 1'b1;
        tick();
        checks++;
        if (bus.dataValid !== 1'b1 || bus.memReadReq !== 1'b0 || bus.memAddress !== 16'h1000) begin
            errors++; $display("FAIL b2b_ignore: got valid=%b req=%b addr=%h want 1 0 1000",
                bus.dataValid, bus.memReadReq, bus.memAddress);
        end
        bus.address = 16'h2000;
        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
        checks++;
        if (bus.memReadReq !== 1'b1 || bus.dataValid !== 1'b0 || bus.memAddress !== 16'h2000) begin
            errors++; $display("FAIL b2b_req: got req=%b valid=%b addr=%h want 1 0 2000",
                bus.memReadReq, bus.dataValid, bus.memAddress);
        end
        // startRead still high in REQ must not disturb the address.
        bus.address = 16'h5555;
        tick();
        bus.startRead = 1'b0;
        checks++;
        if (bus.memAddress !== 16'h2000) begin
            errors++; $display("FAIL b2b_hold: got addr=%h want 2000", bus.memAddress);
        end
        bus.memReady = 1'b1;
        bus.memData  = 8'h22;
        sb_q.push_back('{is_timeout: 1'b0, data: 8'h22});
        n = 0;
        while (bus.dataValid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        bus.memReady = 1'b0;
        checks++;
        if (bus.dataValid !== 1'b1) begin
            errors++; $display("FAIL b2b_wait: got valid=%b want 1 within 10 cycles", bus.dataValid);
        end
        e = sb_q.pop_front();
        checks++;
        if (bus.busOutputs !== {OUTPUT_COUNT{e.data}}) begin
            errors++; $display("FAIL b2b_data: got %h want %h", bus.busOutputs, {OUTPUT_COUNT{e.data}});
        end
        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.address   = 16'h4000;
        bus.startRead = 1'b1;
        tick();
        bus.startRead = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.memReadReq, bus.busy, bus.dataValid} !== 3'b000 || bus.busOutputs !== 16'h0000
            || bus.memAddress !== 16'h0000) begin
            errors++; $display("FAIL rstmid_state: got req/busy/valid=%b bus=%h addr=%h want 000 0000 0000",
                {bus.memReadReq, bus.busy, bus.dataValid}, bus.busOutputs, bus.memAddress);
        end
        bus.memReady = 1'b1;
        bus.memData  = 8'h77;
        tick();
        tick();
        bus.memReady = 1'b0;
        checks++;
        if (bus.dataValid !== 1'b0 || bus.busOutputs !== 16'h0000) begin
            errors++; $display("FAIL rstmid_ready: got valid=%b bus=%h want 0 0000",
                bus.dataValid, bus.busOutputs);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_zero_wait();
        test_wait_states(TIMEOUT, 1'b1, 8'h3C);
        test_wait_states(TIMEOUT, 1'b0, 8'hEE);
        test_wait_states(TIMEOUT, 1'b1, 8'h5A);
        test_wait_states(1, 1'b1, 8'hC3);
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left: got %0d entries want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/memory_data_latch.md
Name: memory_data_latch

Overview:
- Input data latch between the external memory interface and the internal dataflow registers.
- Issues one read per request, waits for memory to respond and captures the returned byte.
- Presents the byte on bus outputs, replicated once per consuming register, until a consumer takes it.
- Times out on memory that never responds. It is the upstream producer for the bus-loaded registers.

Parameters:
- WIDTH, 8, data byte width.
- ADDR_WIDTH, 16, memory address width.
- OUTPUT_COUNT, 1, number of replicated WIDTH-bit copies on busOutputs.
- TIMEOUT, 15, maximum wait-state cycles in REQ before abort; 0 disables the timeout.
- DEFAULT_VALUE, all zeros, latch reset value.

Ports:
- clk  in  1  clock. Interface timing: one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- startRead  in  1  request a read of address.
- address  in  ADDR_WIDTH  read address, sampled with startRead.
- memAddress  out  ADDR_WIDTH  registered address driven to memory.
- memReadReq  out  1  read request to memory, registered.
- memReady  in  1  memory has memData valid this cycle.
- memData  in  WIDTH  memory read data.
- consume  in  1  downstream register has loaded the byte (its bus read enable for this source).
- busOutputs  out  WIDTH*OUTPUT_COUNT  latched byte replicated OUTPUT_COUNT times.
- dataValid  out  1  latched byte is fresh and unconsumed.
- busy  out  1  high in REQ.
- timeoutError  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (rst high at a clk edge, any state):
  - State goes to IDLE; latch = DEFAULT_VALUE; memAddress = 0.
  - memReadReq, dataValid, busy and timeoutError = 0; wait counter = 0.
  - Reset overrides all other inputs on the same edge.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE: startRead -> REQ; capture address into memAddress; clear counter. Otherwise stay.
  - REQ (memReadReq = 1, busy = 1):
    - memReady -> FULL; latch <= memData; dataValid set.
    - Otherwise, counter == TIMEOUT with TIMEOUT != 0 -> IDLE with timeoutError pulse; latch unchanged.
    - Otherwise counter increments.
  - FULL (dataValid = 1):
    - consume and startRead on the same edge -> REQ with the new address (back-to-back).
    - consume alone -> IDLE.
    - startRead without consume -> ignored, not queued; stay in FULL.
- Latency:
  - startRead at edge k -> memReadReq high after edge k.
  - memReady sampled at edge k+1 (zero wait states) -> dataValid high and memReadReq low after edge k+1.
  - Minimum startRead-to-dataValid is 2 edges.
- Wait counter:
  - Width is clog2(TIMEOUT+1), minimum 1.
  - Counts REQ edges without memReady.
  - Abort happens on the edge where counter == TIMEOUT, i.e. after TIMEOUT+1 REQ cycles without ready.
- Simultaneous memReady and timeout on the same edge: memReady wins; no error.
- Ignored inputs:
  - startRead while in REQ is ignored; address and memAddress hold.
  - memReady outside REQ is ignored.
  - consume outside FULL is ignored.
- busOutputs:
  - Always shows the latch, including after consume and after a timeout.
  - All OUTPUT_COUNT copies are identical.
- timeoutError is high for exactly one cycle, then 0.

Test Plan:
1. Reset then idle:
   - Hold rst 2 cycles, with memReady = 1 and startRead = 1 asserted during reset.
   - Required: after release, busOutputs = 0x00, dataValid = 0, memReadReq = 0, memAddress = 0x0000, state IDLE.
2. Zero-wait read:
   - startRead with address 0x1234; memReady = 1 with memData 0xA5 in the first REQ cycle.
   - Required: memAddress = 0x1234; memReadReq high for exactly 1 cycle; dataValid = 1 two edges after start; busOutputs = 0xA5 (OUTPUT_COUNT = 2 -> 0xA5A5).
   - Then consume = 1: dataValid = 0 next cycle; busOutputs stays 0xA5.
3. Wait states and timeout boundary (TIMEOUT = 3):
   - memReady on the 4th REQ cycle -> data accepted (0x3C); no error.
   - Repeat with memReady never asserted -> memReadReq drops after the 4th REQ cycle; timeoutError = 1 for one cycle; busOutputs still 0x3C.
   - Repeat with memReady asserted on that same 4th cycle -> ready wins; no error.
4. Back-to-back reads:
   - In FULL holding 0x11, assert consume and startRead (address 0x2000) together.
   - Required: next cycle in REQ with memAddress = 0x2000; dataValid = 0.
   - Also: startRead without consume while in FULL -> stays FULL; memAddress unchanged.
5. Reset mid-operation:
   - Assert rst during REQ after 2 wait cycles.
   - Required: next cycle memReadReq = 0, busy = 0, busOutputs = DEFAULT_VALUE.
   - A subsequent memReady = 1 is ignored and dataValid stays 0.
